// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the TX frame scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int STATS_WIDTH = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    onehot   = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && valid[cand_idx]) begin
        any              = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// Round-robin frame scheduler feeding a serial transmitter with fixed frame time and gap.
// Optional feature: define TX_SCHED_STATS_EN to add the frames_sent_out accept counter.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 26,
  parameter int DATA_PERIOD = 20,
  parameter int GAP_CYCLES  = 40,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          tx_trigger_out,
  output logic [DATA_WIDTH-1:0]         tx_data_out,
  output logic                          busy_out,
  output logic [IDX_W-1:0]              grant_idx_out,
  output logic [1:0]                    state_dbg_out
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]        frames_sent_out
`endif
);

  // Handshake: a frame transfers on a clock edge where req_valid_in[i] and
  // req_ready_out[i] are both high; ready is only offered in IDLE, never in reset.

  localparam int FRAME_CYCLES = DATA_WIDTH * DATA_PERIOD;
  localparam int CNT_MAX      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic                  trig_q, trig_d;
  logic [NUM_REQ-1:0]    ready;
  logic                  accept;

  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid  (req_valid_in),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    grant_d  = grant_q;
    trig_d   = 1'b0;
    ready    = '0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && !rst_in) begin
          ready   = pick_onehot;
          accept  = 1'b1;
          grant_d = pick_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) data_d = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
          end
          rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          cnt_d    = FRAME_LOAD;
          trig_d   = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      grant_q  <= '0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      trig_q   <= trig_d;
    end
  end

  assign req_ready_out  = ready;
  assign tx_trigger_out = trig_q;
  assign tx_data_out    = data_q;
  assign grant_idx_out  = grant_q;
  assign busy_out       = (state_q != IDLE);
  assign state_dbg_out  = state_q;

`ifdef TX_SCHED_STATS_EN
  logic [STATS_WIDTH-1:0] frames_sent_q, frames_sent_d;

  always_comb begin
    frames_sent_d = frames_sent_q;
    if (accept) frames_sent_d = frames_sent_q + STATS_WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) frames_sent_q <= '0;
    else        frames_sent_q <= frames_sent_d;
  end

  assign frames_sent_out = frames_sent_q;
`endif

endmodule
